// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle RV32I control FSM:
// opcodes, state codes, ALU op codes, PC/writeback select codes.
package mc_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_COPYB = 4'd10
    } alu_op_t;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LUI    = 4'd1,
        CLS_AUIPC  = 4'd2,
        CLS_JAL    = 4'd3,
        CLS_JALR   = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_LOAD   = 4'd6,
        CLS_STORE  = 4'd7,
        CLS_OPIMM  = 4'd8,
        CLS_OP     = 4'd9
    } op_cls_t;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // funct3/funct7[5] to ALU op; the alt bit selects SUB only for
    // register-register ops, but always selects SRA over SRL
    function automatic alu_op_t alu_funct(
        input logic [2:0] f3,
        input logic       alt,
        input logic       is_reg
    );
        alu_op_t op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Memory request handshake between the control FSM (master)
// and the memory port (slave).
interface mc_ctrl_fsm_if;

    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decode: opcode class, illegal flag
// and the ALU operation the instruction needs in EXEC.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alt,
    output op_cls_t    cls,
    output logic       illegal,
    output alu_op_t    alu_op
);

    // map opcode to class; anything outside the base set is illegal
    always_comb begin
        cls     = CLS_NONE;
        illegal = 1'b0;
        alu_op  = ALU_ADD;
        unique case (opcode)
            OPC_LUI: begin
                cls    = CLS_LUI;
                alu_op = ALU_COPYB;
            end
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_BRANCH: begin
                cls    = CLS_BRANCH;
                alu_op = ALU_SUB;
            end
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_OPIMM: begin
                cls    = CLS_OPIMM;
                alu_op = alu_funct(funct3, alt, 1'b0);
            end
            OPC_OP: begin
                cls    = CLS_OP;
                alu_op = alu_funct(funct3, alt, 1'b1);
            end
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb/trap).
// Define MC_CTRL_PERF_EN to add cycle_cnt/instret_cnt outputs.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       inst,
    input  logic              br_taken,
    mc_ctrl_fsm_if.master     bus,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              reg_we,
    output logic [1:0]        wb_sel,
    output logic              alu_a_sel,
    output logic              alu_b_sel,
    output logic [3:0]        alu_op,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [2:0]        state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt
`endif
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST =
        CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        st;
    op_cls_t       cls_q;
    op_cls_t       cls_d;
    alu_op_t       alu_q;
    alu_op_t       alu_d;
    logic          illegal;
    logic          rd_nz_q;
    logic [1:0]    cause_q;
    logic [CW-1:0] wait_cnt;
    logic          timeout;
    logic          unused_inst;

    // rs1/rs2/upper immediate bits belong to the datapath
    assign unused_inst = ^{inst[31], inst[29:15]};

    mc_ctrl_decode u_dec (
        .opcode  (inst[6:0]),
        .funct3  (inst[14:12]),
        .alt     (inst[30]),
        .cls     (cls_d),
        .illegal (illegal),
        .alu_op  (alu_d)
    );

    // the last permitted wait cycle; a zero limit never expires
    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    assign trap_cause = cause_q;
    assign state      = st;

    // state sequencing, latched decode and memory wait counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st       <= ST_IDLE;
            cls_q    <= CLS_NONE;
            alu_q    <= ALU_ADD;
            rd_nz_q  <= 1'b0;
            cause_q  <= CAUSE_NONE;
            wait_cnt <= '0;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    st       <= ST_FETCH;
                    wait_cnt <= '0;
                end
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        st       <= ST_DECODE;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        st      <= ST_TRAP;
                        cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_DECODE: begin
                    cls_q   <= cls_d;
                    alu_q   <= alu_d;
                    rd_nz_q <= |inst[11:7];
                    if (illegal) begin
                        st      <= ST_TRAP;
                        cause_q <= CAUSE_ILLEGAL;
                    end else begin
                        st <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    wait_cnt <= '0;
                    if (cls_q == CLS_LOAD || cls_q == CLS_STORE)
                        st <= ST_MEM;
                    else if (cls_q == CLS_BRANCH)
                        st <= ST_FETCH;
                    else
                        st <= ST_WB;
                end
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        st <= (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        st      <= ST_TRAP;
                        cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_WB: begin
                    st       <= ST_FETCH;
                    wait_cnt <= '0;
                end
                ST_TRAP: st <= ST_TRAP;
                default: st <= ST_IDLE;
            endcase
        end
    end

    // strobes decoded from state and the latched instruction class
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        pc_sel           = PC_PLUS4;
        reg_we           = 1'b0;
        wb_sel           = WB_ALU;
        alu_a_sel        = 1'b0;
        alu_b_sel        = 1'b0;
        alu_op           = ALU_ADD;
        trap             = 1'b0;
        unique case (st)
            ST_FETCH: begin
                bus.mem_req = 1'b1;
                ir_we       = bus.mem_ready;
            end
            ST_EXEC: begin
                alu_op    = alu_q;
                alu_a_sel = cls_q inside {CLS_AUIPC, CLS_JAL};
                alu_b_sel = !(cls_q inside {CLS_OP, CLS_BRANCH});
                if (cls_q == CLS_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                end
            end
            ST_MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = 1'b1;
                bus.mem_we       = (cls_q == CLS_STORE);
                if (cls_q == CLS_STORE && bus.mem_ready)
                    pc_we = 1'b1;
            end
            ST_WB: begin
                reg_we = rd_nz_q;
                pc_we  = 1'b1;
                unique case (cls_q)
                    CLS_JAL: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_IMM;
                    end
                    CLS_JALR: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_JALR;
                    end
                    CLS_LOAD: wb_sel = WB_MEM;
                    default: ;
                endcase
            end
            ST_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    logic retire;

    assign retire = (st == ST_EXEC && cls_q == CLS_BRANCH) ||
                    (st == ST_MEM && cls_q == CLS_STORE && bus.mem_ready) ||
                    (st == ST_WB);

    // free-running activity and retired-instruction counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (st != ST_IDLE && st != ST_TRAP)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (retire)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed testbench for mc_ctrl_fsm.
// Covers reset, each instruction class, waits, timeout and traps.
module tb_mc_ctrl_fsm;

    logic        clk;
    logic        rstn;
    logic [31:0] inst;
    logic        br_taken;

    mc_ctrl_fsm_if bus ();
    mc_ctrl_fsm_if bus0 ();

    logic       ir_we, pc_we, reg_we, alu_a_sel, alu_b_sel, trap;
    logic [1:0] pc_sel, wb_sel, trap_cause;
    logic [3:0] alu_op;
    logic [2:0] state;

    logic       ir_we0, pc_we0, reg_we0, alu_a_sel0, alu_b_sel0, trap0;
    logic [1:0] pc_sel0, wb_sel0, trap_cause0;
    logic [3:0] alu_op0;
    logic [2:0] state0;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt, cycle_cnt0, instret_cnt0;
`endif

    int total = 0;
    int bad   = 0;

    logic [21:0] outs;
    assign outs = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_we,
                   pc_we, pc_sel, reg_we, wb_sel, alu_a_sel, alu_b_sel,
                   alu_op, trap, trap_cause, state};

    mc_ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .inst       (inst),
        .br_taken   (br_taken),
        .bus        (bus),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .alu_a_sel  (alu_a_sel),
        .alu_b_sel  (alu_b_sel),
        .alu_op     (alu_op),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state      (state)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    mc_ctrl_fsm #(.MEM_TIMEOUT(0)) dut0 (
        .clk        (clk),
        .rstn       (rstn),
        .inst       (inst),
        .br_taken   (br_taken),
        .bus        (bus0),
        .ir_we      (ir_we0),
        .pc_we      (pc_we0),
        .pc_sel     (pc_sel0),
        .reg_we     (reg_we0),
        .wb_sel     (wb_sel0),
        .alu_a_sel  (alu_a_sel0),
        .alu_b_sel  (alu_b_sel0),
        .alu_op     (alu_op0),
        .trap       (trap0),
        .trap_cause (trap_cause0),
        .state      (state0)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt0),
        .instret_cnt(instret_cnt0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // leaves both DUTs in IDLE, one edge before FETCH
    task automatic do_reset;
        rstn = 1'b0;
        bus.mem_ready = 1'b0;
        br_taken = 1'b0;
        inst = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        total++;
        if (outs !== 22'h0) begin
            bad++;
            $display("FAIL reset_outs got=%h want=0", outs);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL reset_idle got=%0d want=0", state);
        end
        step();
        total++;
        if ({state, bus.mem_req, bus.mem_addr_sel} !== {3'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_fetch got=%b want=001_1_0",
                     {state, bus.mem_req, bus.mem_addr_sel});
        end
    endtask

    // starts and ends in FETCH
    task automatic test_addi;
        inst = 32'h00500093;
        bus.mem_ready = 1'b1;
        #1;
        total++;
        if ({state, bus.mem_req, ir_we} !== {3'd1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL addi_fetch got=%b want=001_1_1",
                     {state, bus.mem_req, ir_we});
        end
        step();
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL addi_decode got=%0d want=2", state);
        end
        step();
        total++;
        if ({state, alu_a_sel, alu_b_sel, alu_op, pc_we} !==
            {3'd3, 1'b0, 1'b1, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL addi_exec got=%b want=011_0_1_0000_0",
                     {state, alu_a_sel, alu_b_sel, alu_op, pc_we});
        end
        step();
        total++;
        if ({state, reg_we, wb_sel, pc_sel, pc_we} !==
            {3'd5, 1'b1, 2'b00, 2'b00, 1'b1}) begin
            bad++;
            $display("FAIL addi_wb got=%b want=101_1_00_00_1",
                     {state, reg_we, wb_sel, pc_sel, pc_we});
        end
        step();
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL addi_refetch got=%0d want=1", state);
        end
    endtask

    task automatic test_load_wait;
        int reqs;
        reqs = 0;
        inst = 32'h0000A103;
        bus.mem_ready = 1'b1;
        step();
        step();
        bus.mem_ready = 1'b0;
        #1;
        total++;
        if ({state, alu_b_sel, alu_op} !== {3'd3, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL load_exec got=%b want=011_1_0000",
                     {state, alu_b_sel, alu_op});
        end
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_ready = 1'b1;
            #1;
            if (state == 3'd4 && bus.mem_req) reqs++;
            total++;
            if ({state, bus.mem_req, bus.mem_we, bus.mem_addr_sel, reg_we} !==
                {3'd4, 1'b1, 1'b0, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL load_mem%0d got=%b want=100_1_0_1_0", i,
                         {state, bus.mem_req, bus.mem_we, bus.mem_addr_sel, reg_we});
            end
            step();
        end
        total++;
        if (reqs !== 4) begin
            bad++;
            $display("FAIL load_req_cycles got=%0d want=4", reqs);
        end
        total++;
        if ({state, wb_sel, reg_we, pc_sel, bus.mem_req} !==
            {3'd5, 2'b01, 1'b1, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL load_wb got=%b want=101_01_1_00_0",
                     {state, wb_sel, reg_we, pc_sel, bus.mem_req});
        end
        step();
    endtask

    task automatic test_branch;
        for (int t = 1; t >= 0; t--) begin
            inst = 32'h00000463;
            br_taken = t[0];
            bus.mem_ready = 1'b1;
            step();
            step();
            total++;
            if ({state, pc_we, pc_sel, reg_we} !==
                {3'd3, 1'b1, (t == 1) ? 2'b01 : 2'b00, 1'b0}) begin
                bad++;
                $display("FAIL branch_exec taken=%0d got=%b", t,
                         {state, pc_we, pc_sel, reg_we});
            end
            step();
            total++;
            if ({state, reg_we} !== {3'd1, 1'b0}) begin
                bad++;
                $display("FAIL branch_next taken=%0d got=%b want=001_0", t,
                         {state, reg_we});
            end
        end
        br_taken = 1'b0;
    endtask

    task automatic test_store;
        inst = 32'h0020A023;
        bus.mem_ready = 1'b1;
        step();
        step();
        step();
        total++;
        if ({state, bus.mem_req, bus.mem_we, bus.mem_addr_sel, pc_we,
             pc_sel, reg_we} !== {3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL store_mem got=%b want=100_1_1_1_1_00_0",
                     {state, bus.mem_req, bus.mem_we, bus.mem_addr_sel,
                      pc_we, pc_sel, reg_we});
        end
        step();
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL store_next got=%0d want=1", state);
        end
    endtask

    // inst, alu_op, a_sel, b_sel, wb_sel, pc_sel, reg_we
    task automatic test_alu_jump;
        logic [31:0] vi [8];
        logic [11:0] ve [8];
        vi[0] = 32'h402081B3; ve[0] = {4'd1,  1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
        vi[1] = 32'h4030D093; ve[1] = {4'd7,  1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
        vi[2] = 32'h40000093; ve[2] = {4'd0,  1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
        vi[3] = 32'h123452B7; ve[3] = {4'd10, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
        vi[4] = 32'h00000097; ve[4] = {4'd0,  1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
        vi[5] = 32'h0080006F; ve[5] = {4'd0,  1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0};
        vi[6] = 32'h000100E7; ve[6] = {4'd0,  1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0};
        vi[7] = 32'h00500013; ve[7] = {4'd0,  1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            inst = vi[k];
            step();
            step();
            total++;
            if ({state, alu_op, alu_a_sel, alu_b_sel} !==
                {3'd3, ve[k][11:8], ve[k][7], ve[k][6]}) begin
                bad++;
                $display("FAIL alu_exec%0d got=%b want=%b", k,
                         {state, alu_op, alu_a_sel, alu_b_sel},
                         {3'd3, ve[k][11:6]});
            end
            step();
            total++;
            if ({state, wb_sel, pc_sel, reg_we, pc_we} !==
                {3'd5, ve[k][5:4], ve[k][3:2], ve[k][1], 1'b1}) begin
                bad++;
                $display("FAIL alu_wb%0d got=%b want=%b", k,
                         {state, wb_sel, pc_sel, reg_we, pc_we},
                         {3'd5, ve[k][5:1], 1'b1});
            end
            step();
            total++;
            if (state !== 3'd1) begin
                bad++;
                $display("FAIL alu_next%0d got=%0d want=1", k, state);
            end
        end
    endtask

    task automatic test_illegal;
        inst = 32'hFFFFFFFF;
        bus.mem_ready = 1'b1;
        step();
        step();
        for (int c = 0; c < 20; c++) begin
            total++;
            if (outs !== {16'h0, 1'b1, 2'b01, 3'd6}) begin
                bad++;
                $display("FAIL illegal_trap c=%0d got=%h want=%h", c, outs,
                         {16'h0, 1'b1, 2'b01, 3'd6});
            end
            step();
        end
        do_reset();
        total++;
        if ({state, trap, trap_cause} !== {3'd0, 1'b0, 2'b00}) begin
            bad++;
            $display("FAIL illegal_reset got=%b want=000_0_00",
                     {state, trap, trap_cause});
        end
        step();
    endtask

    // ready arriving on the 15th wait cycle still completes the fetch
    task automatic test_timeout_edge;
        inst = 32'h00500093;
        bus.mem_ready = 1'b0;
        repeat (14) step();
        bus.mem_ready = 1'b1;
        #1;
        total++;
        if ({state, ir_we} !== {3'd1, 1'b1}) begin
            bad++;
            $display("FAIL tmo_edge_fetch got=%b want=001_1", {state, ir_we});
        end
        step();
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL tmo_edge_decode got=%0d want=2", state);
        end
        step();
        step();
        step();
    endtask

    task automatic test_timeout;
        int n;
        n = 0;
        bus.mem_ready = 1'b0;
        while (state == 3'd1 && n < 100) begin
            n++;
            step();
        end
        total++;
        if (n !== 15) begin
            bad++;
            $display("FAIL tmo_cycles got=%0d want=15", n);
        end
        total++;
        if ({state, trap, trap_cause, bus.mem_req} !==
            {3'd6, 1'b1, 2'b10, 1'b0}) begin
            bad++;
            $display("FAIL tmo_trap got=%b want=110_1_10_0",
                     {state, trap, trap_cause, bus.mem_req});
        end
        total++;
        if ({state0, trap0, bus0.mem_req} !== {3'd1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL tmo_disabled got=%b want=001_0_1",
                     {state0, trap0, bus0.mem_req});
        end
        do_reset();
        step();
    endtask

    task automatic test_mid_mem_reset;
        inst = 32'h0000A103;
        bus.mem_ready = 1'b1;
        step();
        step();
        bus.mem_ready = 1'b0;
        step();
        total++;
        if ({state, bus.mem_req} !== {3'd4, 1'b1}) begin
            bad++;
            $display("FAIL rst_mem_pre got=%b want=100_1", {state, bus.mem_req});
        end
        rstn = 1'b0;
        #1;
        total++;
        if (outs !== 22'h0) begin
            bad++;
            $display("FAIL rst_mem_outs got=%h want=0", outs);
        end
`ifdef MC_CTRL_PERF_EN
        total++;
        if ({cycle_cnt, instret_cnt} !== 64'h0) begin
            bad++;
            $display("FAIL rst_mem_perf got=%h want=0", {cycle_cnt, instret_cnt});
        end
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1;
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL rst_mem_idle got=%0d want=0", state);
        end
        step();
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL rst_mem_fetch got=%0d want=1", state);
        end
    endtask

`ifdef MC_CTRL_PERF_EN
    task automatic test_perf;
        do_reset();
        inst = 32'h00500093;
        bus.mem_ready = 1'b1;
        repeat (5) step();
        total++;
        if ({cycle_cnt, instret_cnt} !== {32'd4, 32'd1}) begin
            bad++;
            $display("FAIL perf_addi got=%0d/%0d want=4/1", cycle_cnt, instret_cnt);
        end
    endtask
`endif

    initial begin
        rstn = 1'b0;
        inst = 32'h0;
        br_taken = 1'b0;
        bus.mem_ready = 1'b0;
        bus0.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_load_wait();
        test_branch();
        test_store();
        test_alu_jump();
        test_illegal();
        test_timeout_edge();
        test_timeout();
        test_mid_mem_reset();
`ifdef MC_CTRL_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
